// File: rtl/psddivide_pkg.sv
// rtl/psddivide_pkg.sv - shared state encoding and counter sizing for the psddivide divider family
// Purpose: constants and helpers shared between the divider controller and its datapath.
//   state_t       : controller FSM encoding (IDLE=0, RUN=1)
//   NITER_DEFAULT : default number of shift/subtract iterations
//   calc_last     : counter value of the stop cycle
//   calc_cw       : counter/step width needed to hold calc_last
package psddivide_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NITER_DEFAULT = 32;

  // One load cycle precedes the iterations, an optional sign-correction
  // cycle follows them, and the stop cycle is the last counter value.
  function automatic int calc_last(input int niter, input int sign_fix);
    return niter + 1 + sign_fix;
  endfunction

  function automatic int calc_cw(input int last);
    return $clog2(last + 1);
  endfunction

endpackage

// File: rtl/psddivide_ctrl_p.sv
// rtl/psddivide_ctrl_p.sv - parametrised sequencing controller for the restoring divider datapath
// Purpose: sequences load / iterate / sign-fix / output-register strobes for an
// N-bit by M-bit sequential restoring divider, with abort, back-to-back issue,
// a done pulse and an overrun flag for dropped requests.
// Ports:
//   clock   : master clock, rising edge
//   reset   : asynchronous active-low reset
//   run     : one-cycle request to start a division
//   abort   : synchronous cancel of the division in flight
//   start   : load operands into the datapath (combinational)
//   iter    : datapath iterates this cycle
//   fix     : datapath applies sign correction this cycle
//   stop    : load output registers this cycle
//   busy    : a division is in flight
//   step    : current counter value, 0 when idle
//   done    : registered pulse one cycle after stop
//   overrun : registered pulse, a run request was dropped
//   aborted : registered pulse, an abort took effect
module psddivide_ctrl_p
  import psddivide_pkg::*;
#(
  parameter  int NITER     = NITER_DEFAULT,
  parameter  int SIGN_FIX  = 0,
  parameter  int BACK2BACK = 0,
  localparam int LAST      = calc_last(NITER, SIGN_FIX),
  localparam int CW        = calc_cw(LAST)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          abort,
  output logic          start,
  output logic          iter,
  output logic          fix,
  output logic          stop,
  output logic          busy,
  output logic [CW-1:0] step,
  output logic          done,
  output logic          overrun,
  output logic          aborted
);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] NITER_C = CW'(NITER);
  localparam logic [CW-1:0] FIX_C   = CW'(NITER + 1);
  localparam logic [CW-1:0] LAST_C  = CW'(LAST);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;

  // stop is masked by abort so an aborted job never loads its outputs,
  // and so a back-to-back accept cannot happen in an abort cycle.
  assign stop   = (cnt == LAST_C) & ~abort;
  assign accept = (state == IDLE) | ((BACK2BACK != 0) & stop);
  // Gating with reset keeps the datapath from loading while held in reset.
  assign start  = run & accept & ~abort & reset;
  assign busy   = (cnt >= ONE) && (cnt <= LAST_C);
  assign iter   = (cnt >= ONE) && (cnt <= NITER_C);
  assign fix    = (SIGN_FIX != 0) && (cnt == FIX_C);
  assign step   = cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt < LAST_C) begin
          cnt_nxt   = cnt + ONE;
        end else if (start) begin
          cnt_nxt   = ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      done    <= stop;
      overrun <= run & ~accept & ~abort;
      aborted <= abort & (state == RUN);
    end
  end

endmodule

// File: tb/tb_psddivide_ctrl_p.sv
// tb/tb_psddivide_ctrl_p.sv - randomized and directed bench for psddivide_ctrl_p against a timestamp model
module tb_psddivide_ctrl_p;

  localparam int ND = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic run   = 1'b0;
  logic abort = 1'b0;

  logic [ND-1:0] start_v, iter_v, fix_v, stop_v, busy_v, done_v, over_v, abt_v;
  logic [5:0] step0;
  logic [4:0] step1;
  logic [3:0] step2, step3;

  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  // Model configuration per instance.
  int m_niter [ND];
  int m_sf    [ND];
  int m_b2b   [ND];

  // Model state: a job in flight is described by the cycle its run was accepted.
  bit act    [ND];
  int t0     [ND];
  bit p_done [ND];
  bit p_over [ND];
  bit p_abt  [ND];

  // Event counters over a window of cycles starting at mark.
  bit cnt_en = 1'b0;
  int mark = 0;
  int win = 0;
  int n_busy[ND], n_iter[ND], n_fix[ND], n_stop[ND], n_done[ND];
  int n_over[ND], n_abt[ND], n_start[ND], fs[ND], fd[ND], fo[ND];

  psddivide_ctrl_p #(.NITER(32), .SIGN_FIX(0), .BACK2BACK(0)) d0 (
    .clock(clock), .reset(reset), .run(run), .abort(abort),
    .start(start_v[0]), .iter(iter_v[0]), .fix(fix_v[0]), .stop(stop_v[0]),
    .busy(busy_v[0]), .step(step0), .done(done_v[0]), .overrun(over_v[0]), .aborted(abt_v[0]));

  psddivide_ctrl_p #(.NITER(16), .SIGN_FIX(1), .BACK2BACK(0)) d1 (
    .clock(clock), .reset(reset), .run(run), .abort(abort),
    .start(start_v[1]), .iter(iter_v[1]), .fix(fix_v[1]), .stop(stop_v[1]),
    .busy(busy_v[1]), .step(step1), .done(done_v[1]), .overrun(over_v[1]), .aborted(abt_v[1]));

  psddivide_ctrl_p #(.NITER(8), .SIGN_FIX(0), .BACK2BACK(1)) d2 (
    .clock(clock), .reset(reset), .run(run), .abort(abort),
    .start(start_v[2]), .iter(iter_v[2]), .fix(fix_v[2]), .stop(stop_v[2]),
    .busy(busy_v[2]), .step(step2), .done(done_v[2]), .overrun(over_v[2]), .aborted(abt_v[2]));

  psddivide_ctrl_p #(.NITER(8), .SIGN_FIX(0), .BACK2BACK(0)) d3 (
    .clock(clock), .reset(reset), .run(run), .abort(abort),
    .start(start_v[3]), .iter(iter_v[3]), .fix(fix_v[3]), .stop(stop_v[3]),
    .busy(busy_v[3]), .step(step3), .done(done_v[3]), .overrun(over_v[3]), .aborted(abt_v[3]));

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  function automatic int stp(input int i);
    case (i)
      0:       return int'(step0);
      1:       return int'(step1);
      2:       return int'(step2);
      default: return int'(step3);
    endcase
  endfunction

  task automatic chk(input int i, input string nm, input int got, input int exp_v);
    vectors++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s[d%0d] cyc=%0d got=%0d exp=%0d", nm, i, cyc, got, exp_v);
    end
  endtask

  task automatic lit(input string nm, input int got, input int exp_v);
    vectors++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp_v);
    end
  endtask

  // Compare process: every cycle, predict outputs from the job timestamp and
  // the current inputs, check, then advance the model to the next cycle.
  always @(negedge clock) begin : cmp
    int L, ph;
    bit acc, e_start, e_busy, e_iter, e_fix, e_stop;
    for (int i = 0; i < ND; i++) begin
      if (!reset) begin
        act[i] = 1'b0; p_done[i] = 1'b0; p_over[i] = 1'b0; p_abt[i] = 1'b0;
      end
      L       = m_niter[i] + 1 + m_sf[i];
      ph      = act[i] ? (cyc - t0[i]) : 0;
      e_busy  = act[i];
      e_iter  = act[i] && (ph <= m_niter[i]);
      e_fix   = act[i] && (m_sf[i] == 1) && (ph == m_niter[i] + 1);
      e_stop  = act[i] && (ph == L) && !abort;
      acc     = !act[i] || ((m_b2b[i] == 1) && e_stop);
      e_start = run && acc && !abort && reset;

      chk(i, "start",   int'(start_v[i]), int'(e_start));
      chk(i, "busy",    int'(busy_v[i]),  int'(e_busy));
      chk(i, "iter",    int'(iter_v[i]),  int'(e_iter));
      chk(i, "fix",     int'(fix_v[i]),   int'(e_fix));
      chk(i, "stop",    int'(stop_v[i]),  int'(e_stop));
      chk(i, "step",    stp(i),           ph);
      chk(i, "done",    int'(done_v[i]),  int'(p_done[i]));
      chk(i, "overrun", int'(over_v[i]),  int'(p_over[i]));
      chk(i, "aborted", int'(abt_v[i]),   int'(p_abt[i]));

      if (cnt_en && (cyc >= mark) && (cyc - mark <= win)) begin
        n_busy[i]  += int'(busy_v[i]);
        n_iter[i]  += int'(iter_v[i]);
        n_fix[i]   += int'(fix_v[i]);
        n_stop[i]  += int'(stop_v[i]);
        n_done[i]  += int'(done_v[i]);
        n_over[i]  += int'(over_v[i]);
        n_abt[i]   += int'(abt_v[i]);
        n_start[i] += int'(start_v[i]);
        if (stop_v[i] && fs[i] < 0) fs[i] = cyc - mark;
        if (done_v[i] && fd[i] < 0) fd[i] = cyc - mark;
        if (over_v[i] && fo[i] < 0) fo[i] = cyc - mark;
      end

      p_done[i] = e_stop && reset;
      p_over[i] = run && !acc && !abort && reset;
      p_abt[i]  = abort && act[i] && reset;
      if (e_start) begin
        act[i] = 1'b1;
        t0[i]  = cyc;
      end else if (act[i] && (abort || ph == L)) begin
        act[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr(input int w);
    for (int i = 0; i < ND; i++) begin
      n_busy[i] = 0; n_iter[i] = 0; n_fix[i] = 0; n_stop[i] = 0; n_done[i] = 0;
      n_over[i] = 0; n_abt[i] = 0; n_start[i] = 0; fs[i] = -1; fd[i] = -1; fo[i] = -1;
    end
    mark   = cyc;
    win    = w;
    cnt_en = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int eb[ND], ei[ND], ef[ND], es[ND];
    m_niter = '{32, 16, 8, 8};
    m_sf    = '{0, 1, 0, 0};
    m_b2b   = '{0, 0, 1, 0};
    for (int i = 0; i < ND; i++) begin
      act[i] = 1'b0; t0[i] = 0; p_done[i] = 1'b0; p_over[i] = 1'b0; p_abt[i] = 1'b0;
    end

    // Reset state, with run requested while reset is held.
    repeat (3) tick();
    run = 1'b1;
    #1;
    lit("rst_start", int'(start_v), 0);
    lit("rst_busy", int'(busy_v), 0);
    lit("rst_step0", int'(step0), 0);
    lit("rst_pulses", int'({done_v, over_v, abt_v}), 0);
    tick();
    run   = 1'b0;
    reset = 1'b1;
    repeat (2) tick();

    // Single job: latency and strobe counts per configuration.
    clr(40);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (45) tick();
    cnt_en = 1'b0;
    eb = '{33, 18, 9, 9};
    ei = '{32, 16, 8, 8};
    ef = '{0, 1, 0, 0};
    es = '{33, 18, 9, 9};
    for (int i = 0; i < ND; i++) begin
      lit($sformatf("single_busy_d%0d", i), n_busy[i], eb[i]);
      lit($sformatf("single_iter_d%0d", i), n_iter[i], ei[i]);
      lit($sformatf("single_fix_d%0d", i), n_fix[i], ef[i]);
      lit($sformatf("single_stop_at_d%0d", i), fs[i], es[i]);
      lit($sformatf("single_done_at_d%0d", i), fd[i], es[i] + 1);
    end

    // Runs at offsets 0 and 9: back-to-back vs gapped NITER=8 controllers.
    clr(25);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (8) tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (30) tick();
    cnt_en = 1'b0;
    lit("b2b_stops", n_stop[2], 2);
    lit("b2b_busy", n_busy[2], 18);
    lit("b2b_done", n_done[2], 2);
    lit("b2b_over", n_over[2], 0);
    lit("gap_stops", n_stop[3], 1);
    lit("gap_over", n_over[3], 1);
    lit("gap_over_at", fo[3], 10);

    // Abort at offset 5.
    clr(40);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    lit("abort_step0", int'(step0), 0);
    lit("abort_busy", int'(busy_v), 0);
    lit("abort_pulse", int'(abt_v), 4'hf);
    repeat (40) tick();
    cnt_en = 1'b0;
    lit("abort_stops", n_stop[0] + n_stop[1] + n_stop[2] + n_stop[3], 0);
    lit("abort_dones", n_done[0] + n_done[1] + n_done[2] + n_done[3], 0);
    lit("abort_count_d0", n_abt[0], 1);

    // Abort together with run while idle.
    abort = 1'b1;
    run   = 1'b1;
    #1;
    lit("abort_run_idle_start", int'(start_v), 0);
    tick();
    abort = 1'b0;
    run   = 1'b0;
    lit("abort_idle_pulse", int'(abt_v), 0);
    lit("abort_idle_busy", int'(busy_v), 0);
    tick();

    // Asynchronous reset mid-job, off the clock edge.
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (19) tick();
    @(negedge clock);
    #2;
    lit("pre_reset_busy_d0", int'(busy_v[0]), 1);
    reset = 1'b0;
    #1;
    lit("arst_busy", int'(busy_v), 0);
    lit("arst_step0", int'(step0), 0);
    lit("arst_pulses", int'({done_v, over_v, abt_v}), 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    clr(40);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (42) tick();
    cnt_en = 1'b0;
    lit("post_reset_stop_at", fs[0], 33);
    lit("post_reset_busy", n_busy[0], 33);

    // run held high for 40 cycles.
    clr(35);
    run = 1'b1;
    repeat (40) tick();
    run = 1'b0;
    cnt_en = 1'b0;
    lit("hold_starts", n_start[0], 2);
    lit("hold_overruns", n_over[0], 33);
    lit("hold_first_over", fo[0], 2);
    repeat (40) tick();

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      run   = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end
    run   = 1'b0;
    abort = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/psddivide_ctrl_p.md
Name: psddivide_ctrl_p

Overview:
- Parametrised controller for the sequential restoring divider family (N-bit dividend / M-bit divisor datapaths).
- Generalises the fixed 32-iteration controller: configurable iteration count, optional sign-correction cycle, back-to-back issue, abort, done pulse and overrun flag.
- Sits beside the divider datapath and drives its load, iterate, fix and output-register strobes.

Parameters:
- NITER, 32, number of shift/subtract iterations (quotient bits); legal 1..62.
- SIGN_FIX, 0, 1 inserts one sign-correction cycle after the iterations.
- BACK2BACK, 0, 1 accepts a new run in the stop cycle with no idle gap.
- LAST (local), NITER+1+SIGN_FIX, final counter value (stop cycle).
- CW (local), $clog2(LAST+1), counter width.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  one-cycle request to start a division.
- abort  in  1  synchronous cancel of the division in flight.
- start  out  1  load operands into the datapath (combinational).
- iter  out  1  datapath performs one iteration this cycle.
- fix  out  1  datapath performs sign correction this cycle.
- stop  out  1  load output registers this cycle.
- busy  out  1  a division is in flight.
- step  out  CW  current counter value, 0 when idle.
- done  out  1  registered pulse one cycle after stop.
- overrun  out  1  registered pulse: run was dropped.
- aborted  out  1  registered pulse: abort took effect.

Behaviour:
- States: IDLE, RUN. Counter cnt[CW-1:0].
- Reset: reset low asynchronously forces state=IDLE, cnt=0, done=0, overrun=0, aborted=0.
  - While reset is low, start=0 regardless of run.
- Derived signal: accept = (state==IDLE) | (BACK2BACK & stop).
- Combinational outputs:
  - start = run & accept & ~abort.
  - busy = (cnt>=1 && cnt<=LAST).
  - iter = (cnt>=1 && cnt<=NITER).
  - fix = SIGN_FIX & (cnt==NITER+1).
  - stop = (cnt==LAST).
  - step = cnt.
- IDLE: on start, go to RUN with cnt<=1. Otherwise hold with cnt=0.
- RUN, cnt<LAST: cnt<=cnt+1.
- RUN, cnt==LAST:
  - If start (BACK2BACK only), cnt<=1 and stay in RUN.
  - Otherwise cnt<=0 and go to IDLE.
- Latency: run in cycle 0 gives stop in cycle LAST. busy is high for LAST cycles, from cycle 1 to cycle LAST. done is high in cycle LAST+1.
- Back-to-back: with BACK2BACK=1, issue period is LAST cycles and busy never drops between jobs. With BACK2BACK=0, the minimum period is LAST+1.
- Overrun: run & ~accept & ~abort sets overrun for the next cycle only. The dropped run has no other effect.
- Abort:
  - In RUN, abort forces IDLE and cnt=0 at the next edge.
  - stop is masked in the abort cycle, i.e. stop = (cnt==LAST) & ~abort.
  - done is not asserted; aborted pulses the next cycle.
  - abort in IDLE is ignored with no aborted pulse.
  - abort beats run in the same cycle.
- Simultaneous done and new job: done for job k may coincide with cycle 1 of job k+1 (BACK2BACK).
- Reset mid-division discards the job. No done, no aborted.
- Counter never exceeds LAST; a value above LAST cannot be reached.

Decomposition:
- Shared package psddivide_pkg holds:
  - state encoding constants IDLE=0, RUN=1;
  - default NITER=32;
  - the LAST/CW derivation function, shared with the datapath so both agree on step width.
- No sub-module: a single FSM with one counter is the natural granularity.

Test Plan:
- NITER=32, SIGN_FIX=0: run at cycle 0 -> busy cycles 1..33, iter 1..32, stop at cycle 33 (step=33), done at 34, busy=0 at 34.
- NITER=16, SIGN_FIX=1: run at 0 -> iter cycles 1..16, fix at 17, stop at 18, done at 19.
- BACK2BACK=1, NITER=8: run at 0 and at 9 -> stop at 9 and 18, busy continuous 1..18, done at 10 and 19, no overrun. Same stimulus with BACK2BACK=0 -> overrun pulse at 10, only one stop.
- Abort at cycle 5 of a 32-iteration job -> step=0 and busy=0 at 6, aborted=1 at 6, no stop or done. Abort together with run in IDLE -> no start.
- Assert reset low at cycle 20 mid-job, asynchronously off-edge -> busy, step, done, overrun and aborted clear immediately. A run after release gives a normal 33-cycle job.
- run held high for 40 cycles, NITER=32, BACK2BACK=0 -> start only at cycles 0 and 34, overrun high on cycles 2..34 (runs at 1..33 dropped), no counter overshoot.
